// File: rtl/icache_ctrl_if.sv
// Request/refill signal bundle for icache_ctrl.
// Groups the CPU-side fetch port (P_*), flush and the memory refill port (M_*).
// Modports: slave = the cache itself; master = the fetch front end plus instruction memory.
interface icache_ctrl_if;
  logic        P_strobe;
  logic [31:0] P_addr;
  logic        P_rw;
  logic [31:0] P_data;
  logic        P_ready;
  logic        flush;
  logic        M_strobe;
  logic [31:0] M_addr;
  logic        M_rw;
  logic [31:0] M_rdata;
  logic        M_ready;

  modport slave (
    input  P_strobe, P_addr, P_rw, flush, M_rdata, M_ready,
    output P_data, P_ready, M_strobe, M_addr, M_rw
  );

  modport master (
    output P_strobe, P_addr, P_rw, flush, M_rdata, M_ready,
    input  P_data, P_ready, M_strobe, M_addr, M_rw
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache with a line-refill controller.
// Ports: clk, rst (sync, active-high), bus (icache_ctrl_if.slave: P_* fetch port, flush, M_* refill port).
// Optional ICACHE_STATS_EN adds hit_count/miss_count outputs; hit answers two edges after acceptance.
module icache_ctrl #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic          clk,
  input  logic          rst,
  icache_ctrl_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;
  localparam logic [OW-1:0] LAST_WORD = OW'(WORDS_PER_LINE - 1);
  localparam logic [31:0]   NOP_WORD  = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;

  state_t            state, state_d;
  logic [31:0]       req_addr;
  logic              req_rw;
  logic [OW-1:0]     cnt, cnt_d;
  logic              flush_pend;
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tags     [LINES];
  logic [31:0]       data_mem [LINES*WORDS_PER_LINE];

  logic [31:0]       p_data_q, p_data_d;
  logic              p_ready_q, p_ready_d;
  logic              m_strobe_q, m_strobe_d;
  logic [31:0]       m_addr_q, m_addr_d;
  logic              accept, inval, fill_wr, fill_done;

  logic [OW-1:0]     req_off;
  logic [IW-1:0]     req_idx;
  logic [TW-1:0]     req_tag;
  logic              hit;
  logic [31:0]       rd_word;

  assign req_off = req_addr[2 +: OW];
  assign req_idx = req_addr[2+OW +: IW];
  assign req_tag = req_addr[31 -: TW];
  assign hit     = valid[req_idx] && (tags[req_idx] == req_tag);
  assign rd_word = data_mem[{req_idx, req_off}];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    p_ready_d  = 1'b0;
    p_data_d   = p_data_q;
    m_strobe_d = m_strobe_q;
    m_addr_d   = m_addr_q;
    accept     = 1'b0;
    inval      = 1'b0;
    fill_wr    = 1'b0;
    fill_done  = 1'b0;
    unique case (state)
      IDLE: begin
        // A deferred or fresh flush wins; a simultaneous request is retried next cycle and misses.
        if (bus.flush || flush_pend) begin
          inval = 1'b1;
        end else if (bus.P_strobe) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!req_rw) begin
          p_ready_d = 1'b1;
          p_data_d  = NOP_WORD;
          state_d   = IDLE;
        end else if (hit) begin
          p_ready_d = 1'b1;
          p_data_d  = rd_word;
          state_d   = IDLE;
        end else begin
          cnt_d      = '0;
          m_strobe_d = 1'b1;
          m_addr_d   = {req_tag, req_idx, {OW{1'b0}}, 2'b00};
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (bus.M_ready) begin
          fill_wr  = 1'b1;
          cnt_d    = cnt + OW'(1);
          // Offset field wraps inside the line, so the address never leaves it.
          m_addr_d = {req_tag, req_idx, cnt + OW'(1), 2'b00};
          if (cnt == LAST_WORD) begin
            m_strobe_d = 1'b0;
            fill_done  = 1'b1;
            state_d    = RESPOND;
          end
        end
      end
      RESPOND: begin
        p_ready_d = 1'b1;
        p_data_d  = rd_word;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr   <= '0;
      req_rw     <= 1'b1;
      cnt        <= '0;
      flush_pend <= 1'b0;
      valid      <= '0;
      p_data_q   <= NOP_WORD;
      p_ready_q  <= 1'b0;
      m_strobe_q <= 1'b0;
      m_addr_q   <= '0;
    end else begin
      cnt        <= cnt_d;
      p_data_q   <= p_data_d;
      p_ready_q  <= p_ready_d;
      m_strobe_q <= m_strobe_d;
      m_addr_q   <= m_addr_d;
      if (accept) begin
        req_addr <= bus.P_addr;
        req_rw   <= bus.P_rw;
      end
      if (inval)                           flush_pend <= 1'b0;
      else if (bus.flush && state != IDLE) flush_pend <= 1'b1;
      if (inval)          valid          <= '0;
      else if (fill_done) valid[req_idx] <= 1'b1;
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (fill_wr)   data_mem[{req_idx, cnt}] <= bus.M_rdata;
    if (fill_done) tags[req_idx]            <= req_tag;
  end

  assign bus.P_data   = p_data_q;
  assign bus.P_ready  = p_ready_q;
  assign bus.M_strobe = m_strobe_q;
  assign bus.M_addr   = m_addr_q;
  assign bus.M_rw     = 1'b1;

`ifdef ICACHE_STATS_EN
  logic lookup_hit, lookup_miss;
  assign lookup_hit  = (state == LOOKUP) && req_rw && hit;
  assign lookup_miss = (state == LOOKUP) && req_rw && !hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (lookup_hit)  hit_count  <= hit_count + 32'd1;
      if (lookup_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed testbench for icache_ctrl: fetch requester, two-cycle-per-word memory model,
// hand-computed expectations for fills, hits, conflicts, flush, reset abort and writes.
// All comparisons go through check(); one summary line at the end.
module tb_icache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_ctrl_if bus();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_ctrl #(.LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int words_fetched = 0;
  logic [31:0] addr_log[$];
  int exp_hit  = 0;
  int exp_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Line 0x100 holds 0xA0..0xA3; every other word is tagged with its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'hA0 + 32'(a[3:2]);
    return {4'hC, a[27:0]};
  endfunction

  // Memory model: one waiting cycle per word, then M_ready for one cycle.
  initial begin
    bit waited = 1'b0;
    bus.M_ready = 1'b0;
    bus.M_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || !bus.M_strobe) begin
        bus.M_ready = 1'b0;
        waited = 1'b0;
      end else if (bus.M_ready) begin
        bus.M_ready = 1'b0;
        waited = 1'b1;
      end else if (waited) begin
        bus.M_ready = 1'b1;
        bus.M_rdata = mem_word(bus.M_addr);
        addr_log.push_back(bus.M_addr);
        words_fetched++;
        waited = 1'b0;
      end else begin
        waited = 1'b1;
      end
    end
  end

  task automatic do_req(input logic [31:0] addr, input logic rw,
                        output logic [31:0] data, output int lat);
    @(posedge clk); #2;
    words_fetched = 0;
    addr_log.delete();
    bus.P_strobe = 1'b1;
    bus.P_addr   = addr;
    bus.P_rw     = rw;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #2;
      lat++;
      if (bus.P_ready) break;
    end
    check($sformatf("req_done_%h", addr), 32'(bus.P_ready), 32'd1);
    data = bus.P_data;
    bus.P_strobe = 1'b0;
  endtask

  task automatic check_fill(input string name, input logic [31:0] base);
    check({name, "_words"}, 32'(words_fetched), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_maddr%0d", name, i),
            (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF, base + 32'(4 * i));
  endtask

  logic [31:0] d;
  int lat;

  initial begin
    bus.P_strobe = 1'b0;
    bus.P_addr   = '0;
    bus.P_rw     = 1'b1;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_p_ready",  32'(bus.P_ready),  32'd0);
    check("rst_p_data",   bus.P_data,        32'h13);
    check("rst_m_strobe", 32'(bus.M_strobe), 32'd0);
    check("rst_m_addr",   bus.M_addr,        32'h0);
    check("rst_m_rw",     32'(bus.M_rw),     32'd1);
`ifdef ICACHE_STATS_EN
    check("rst_hits", hit_count,  32'd0);
    check("rst_miss", miss_count, 32'd0);
`endif
    rst = 1'b0;

    // Cold miss on 0x104: fill 0x100..0x10C, answer word 1.
    do_req(32'h104, 1'b1, d, lat); exp_miss++;
    check("cold_data", d, 32'hA1);
    check("cold_lat", 32'(lat), 32'd11);
    check_fill("cold", 32'h100);

    // Data holds while P_ready is low.
    repeat (3) @(posedge clk);
    #2;
    check("hold_ready", 32'(bus.P_ready), 32'd0);
    check("hold_data",  bus.P_data,       32'hA1);

    // Hit within the filled line.
    do_req(32'h108, 1'b1, d, lat); exp_hit++;
    check("hit_data",  d, 32'hA2);
    check("hit_lat",   32'(lat), 32'd2);
    check("hit_words", 32'(words_fetched), 32'd0);

    // Conflict on index 0, then the original line misses again.
    do_req(32'h204, 1'b1, d, lat); exp_miss++;
    check("conf_data", d, 32'hC000_0204);
    check_fill("conf", 32'h200);
    do_req(32'h104, 1'b1, d, lat); exp_miss++;
    check("refetch_data", d, 32'hA1);
    check_fill("refetch", 32'h100);

    // Flush pulse during a refill: answer first, invalidate afterwards.
    fork
      do_req(32'h300, 1'b1, d, lat);
      begin
        repeat (4) @(posedge clk);
        #3 bus.flush = 1'b1;
        @(posedge clk);
        #3 bus.flush = 1'b0;
      end
    join
    exp_miss++;
    check("flush_data", d, 32'hC000_0300);
    check("flush_lat", 32'(lat), 32'd11);
    check_fill("flush", 32'h300);
    do_req(32'h300, 1'b1, d, lat); exp_miss++;
    check("postflush_300_data", d, 32'hC000_0300);
    check("postflush_300_words", 32'(words_fetched), 32'd4);
    do_req(32'h104, 1'b1, d, lat); exp_miss++;
    check("postflush_104_data", d, 32'hA1);
    check_fill("postflush_104", 32'h100);
`ifdef ICACHE_STATS_EN
    check("mid_hits", hit_count,  32'(exp_hit));
    check("mid_miss", miss_count, 32'(exp_miss));
`endif

    // Reset after two refill words of a 0x200 miss.
    @(posedge clk); #2;
    words_fetched = 0;
    addr_log.delete();
    bus.P_strobe = 1'b1;
    bus.P_addr   = 32'h200;
    bus.P_rw     = 1'b1;
    for (int g = 0; g < 40 && words_fetched < 2; g++) begin
      @(posedge clk); #2;
    end
    check("abort_two_words", 32'(words_fetched), 32'd2);
    @(posedge clk); #2;
    rst = 1'b1;
    bus.P_strobe = 1'b0;
    @(posedge clk); #2;
    check("abort_m_strobe", 32'(bus.M_strobe), 32'd0);
    check("abort_p_ready",  32'(bus.P_ready),  32'd0);
    check("abort_p_data",   bus.P_data,        32'h13);
    rst = 1'b0;
    exp_hit = 0;
    exp_miss = 0;

    do_req(32'h100, 1'b1, d, lat); exp_miss++;
    check("postrst_data", d, 32'hA0);
    check_fill("postrst", 32'h100);

    // Write request: NOP answer, no memory traffic, array untouched.
    do_req(32'h104, 1'b0, d, lat);
    check("write_data",  d, 32'h13);
    check("write_lat",   32'(lat), 32'd2);
    check("write_words", 32'(words_fetched), 32'd0);
    do_req(32'h10C, 1'b1, d, lat); exp_hit++;
    check("after_write_hit", d, 32'hA3);
    check("after_write_words", 32'(words_fetched), 32'd0);
`ifdef ICACHE_STATS_EN
    check("end_hits", hit_count,  32'(exp_hit));
    check("end_miss", miss_count, 32'(exp_miss));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
Direct-mapped instruction cache array and refill controller. Sits directly downstream of the CPU-side instruction fetch front end.
- Services its P_* request port: P_strobe/P_addr in, P_data/P_ready out.
- On a miss, refills a full line from instruction memory over the M_* port.
- Read-only by design.

Parameters:
LINES, 16, number of cache lines (power of 2, >=2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
P_strobe  input  1  request valid, held by requester until P_ready
P_addr  input  32  byte address of requested instruction
P_rw  input  1  1=read; 0=write (unsupported, see Behaviour)
P_data  output  32  instruction word returned, valid with P_ready
P_ready  output  1  one-cycle completion pulse
flush  input  1  invalidate all lines
M_strobe  output  1  memory read request
M_addr  output  32  memory word address (bits[1:0]=0)
M_rw  output  1  constant 1 (read)
M_rdata  input  32  memory read data, valid with M_ready
M_ready  input  1  memory word accepted/returned this cycle

Behaviour:
- Address split:
  - bits[1:0] ignored
  - word offset W = next log2(WORDS_PER_LINE) bits
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage: per line, valid bit, tag register, and WORDS_PER_LINE data words.
- Reset:
  - state IDLE; all valid bits 0; pending-flush flag 0
  - P_ready 0, P_data 32'h13, M_strobe 0, M_addr 0, M_rw 1
  - Reset mid-refill aborts immediately; M_strobe is 0 from the next cycle.
- States: IDLE, LOOKUP, REFILL, RESPOND.
- IDLE:
  - If flush or pending flag is set: clear all valid bits, clear pending flag. This takes priority over a same-cycle P_strobe, so that request then misses.
  - Else if P_strobe: register P_addr/P_rw and go to LOOKUP.
  - P_strobe in any other state is ignored. The requester holds it until P_ready.
- LOOKUP:
  - P_rw=0: P_ready=1, P_data=32'h13, no array change, go to IDLE.
  - Hit (valid & tag match): P_data=word W, P_ready=1 for one cycle, go to IDLE.
  - Hit latency: request accepted at edge E; P_ready high in the cycle after edge E+1.
  - Miss: go to REFILL with word counter=0, M_strobe=1, M_addr={tag,index,0,2'b00}.
- REFILL:
  - M_strobe stays 1 and M_addr stays stable until M_ready=1.
  - On M_ready: write M_rdata into the data word at the counter, then increment the counter. M_addr advances by 4 on the next cycle.
  - Line-offset arithmetic wraps within the line; fill order is always word 0 to last.
  - After the last word's M_ready: M_strobe=0, set valid and tag, go to RESPOND.
- RESPOND:
  - P_data=requested word (the value captured from memory), P_ready=1 for one cycle, go to IDLE.
  - The next request can be accepted at the following edge.
- flush outside IDLE: sets the pending flag. The current refill completes, the line is written and the requester is answered; the invalidate applies on the first IDLE cycle.
- P_data holds its last value when P_ready=0.
- M_ready outside REFILL is ignored.

Optional Feature:
ICACHE_STATS_EN
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
  - Increment once per LOOKUP hit or miss respectively; P_rw=0 requests count as neither.
  - Counters wrap 0xFFFFFFFF->0 and are unaffected by flush.
- Undefined: no counter ports or logic; behaviour otherwise identical.

Test Plan:
- Cold miss, defaults: P_strobe, P_addr=0x104; memory returns 0xA0,0xA1,0xA2,0xA3 with M_ready one cycle after each strobe. Required: M_addr=0x100,0x104,0x108,0x10C in order; P_ready once with P_data=0xA1.
- Hit after fill: P_addr=0x108 -> no M_strobe; P_data=0xA2; P_ready in the cycle after edge E+1.
- Conflict: P_addr=0x204 (same index 0, tag 2) -> refill at 0x200..0x20C. A subsequent 0x104 misses again and refills 0x100..0x10C.
- Flush: flush pulse asserted during a 0x300 refill. Required: refill completes, P_ready delivered, then all lines invalid; the next 0x300 and 0x104 both miss.
- Reset mid-refill after 2 words. Required: M_strobe 0 and P_ready 0 next cycle, P_data=32'h13; a later 0x100 misses with full 4-word refill.
- P_rw=0 request at 0x104: P_ready with P_data=32'h13, no M_strobe. With ICACHE_STATS_EN, after the above sequence the hit/miss counters match the expected counts.
